// File: rtl/aes128_req_arbiter_if.sv
// Bus bundle for aes128_req_arbiter: requester ports, response channel and AES128 core hookup.
// master = requesters/core side, slave = the arbiter.
interface aes128_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ*128-1:0] req_key;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   core_ce;
    logic [127:0]           core_data_in;
    logic [127:0]           core_key;
    logic [127:0]           core_data_out;
    logic                   core_done;

    modport master (
        output req_valid, req_data, req_key, rsp_ready, core_data_out, core_done,
        input  req_ready, rsp_valid, rsp_data, rsp_id, core_ce, core_data_in, core_key
    );

    modport slave (
        input  req_valid, req_data, req_key, rsp_ready, core_data_out, core_done,
        output req_ready, rsp_valid, rsp_data, rsp_id, core_ce, core_data_in, core_key
    );
endinterface

// File: rtl/aes128_req_arbiter.sv
// Round-robin arbiter sharing one AES128 core between NUM_REQ requesters, one job in flight.
// Optional watchdog on the core's done: define AES_ARB_TIMEOUT_EN (adds the sticky err port).
module aes128_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                 clock,
    input  logic                 reset,
    aes128_req_arbiter_if.slave  bus,
    output logic                 busy
`ifdef AES_ARB_TIMEOUT_EN
    ,
    output logic                 err
`endif
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("aes128_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic              grant_vld;
    logic              accept;
    logic              timeout_hit;
    logic [NUM_REQ-1:0] ready;
    logic              core_ce;
    logic [127:0]      core_data_in;
    logic [127:0]      core_key;
    logic              rsp_valid;
    logic [127:0]      rsp_data;
    logic [ID_W-1:0]   rsp_id;

    // Search starts just after the last winner, wrapping modulo NUM_REQ.
    always_comb begin : grant_search
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant     = rr_ptr;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            idx = sum[ID_W-1:0];
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign accept = (state == IDLE) && grant_vld;

    always_comb begin
        ready = '0;
        if (accept)
            ready[grant] = 1'b1;
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_cnt;

    assign timeout_hit = (state == RUN) && !bus.core_done && (wd_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state != RUN || timeout_hit)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (timeout_hit)
                err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (bus.core_done || timeout_hit) state_nxt = DRAIN;
            // The core drops done one edge after ce falls; restart only once it has.
            DRAIN:   if (!bus.core_done) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= ID_W'(NUM_REQ - 1);
            core_ce      <= 1'b0;
            core_data_in <= '0;
            core_key     <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_id       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    core_data_in <= bus.req_data[{grant, 7'd0} +: 128];
                    core_key     <= bus.req_key[{grant, 7'd0} +: 128];
                    rsp_id       <= grant;
                    rr_ptr       <= grant;
                end
                LOAD: core_ce <= 1'b1;
                RUN: if (bus.core_done) begin
                    rsp_data <= bus.core_data_out;
                    core_ce  <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data <= '0;
                    core_ce  <= 1'b0;
                end
                DRAIN: if (!bus.core_done) rsp_valid <= 1'b1;
                RESP:  if (bus.rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign bus.req_ready    = ready;
    assign bus.core_ce      = core_ce;
    assign bus.core_data_in = core_data_in;
    assign bus.core_key     = core_key;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_data     = rsp_data;
    assign bus.rsp_id       = rsp_id;
endmodule

// File: tb/tb_aes128_req_arbiter.sv
// Bench for aes128_req_arbiter: behavioural AES128 core model, vector table, corner sequences,
// randomized traffic against a round-robin/latency reference model.
module tb_aes128_req_arbiter;
    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 63;
    localparam int ID_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clock = 1'b0;
    logic reset;
    logic busy;
`ifdef AES_ARB_TIMEOUT_EN
    logic err;
`endif
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    aes128_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    aes128_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
`ifdef AES_ARB_TIMEOUT_EN
        ,
        .err   (err)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- AES128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < 4; k++) tmp[4*c+k] = st[4*((c+k)%4)+k];
                st = tmp;
                if (r < 10)
                    for (int c = 0; c < 4; c++) begin
                        a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                        st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
            end
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) st[4*c+k] = st[4*c+k] ^ w[4*r+c][31-8*k -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ---------------- AES128 core model (variable latency) ----------------
    logic [127:0] core_out;
    logic         core_done_r;
    int           core_cnt = 0;
    int           core_lat = 5;
    bit           core_hang = 1'b0;
    bit           core_slow = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            core_done_r <= 1'b0;
            core_cnt    <= 0;
            core_out    <= '0;
        end else if (bus.core_ce) begin
            if (!core_done_r && !core_hang) begin
                if (core_cnt == core_lat - 1) begin
                    core_done_r <= 1'b1;
                    core_out    <= aes_enc(bus.core_data_in, bus.core_key);
                end
                core_cnt <= core_cnt + 1;
            end
        end else begin
            core_done_r <= 1'b0;
            core_cnt    <= 0;
            core_lat    <= core_slow ? 30 : int'($urandom_range(2, 12));
        end
    end

    assign bus.core_done     = core_done_r;
    assign bus.core_data_out = core_out;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {busy, bus.req_ready, bus.core_ce, bus.rsp_valid, bus.rsp_data, bus.rsp_id}, '0);
`ifdef AES_ARB_TIMEOUT_EN
        check({name, " err"}, err, 1'b0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Presents one job, waits for accept and response; completes handshake if rsp_ready is high.
    task automatic do_job(input int port, input logic [127:0] key, input logic [127:0] pt,
                          output logic [127:0] data, output logic [ID_W-1:0] id,
                          output int lat, output int ce_cyc, output bit ok);
        int t0;
        bit got;
        ok = 1'b0; data = '0; id = '0; lat = 0; ce_cyc = 0; got = 1'b0;
        bus.req_data[128*port +: 128] = pt;
        bus.req_key[128*port +: 128]  = key;
        bus.req_valid[port]           = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            if (bus.req_ready[port]) got = 1'b1;
        end
        if (!got) begin
            bus.req_valid[port] = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        t0 = cyc;
        bus.req_valid[port] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (bus.rsp_valid) got = 1'b1;
            else if (bus.core_ce) ce_cyc++;
        end
        if (!got) return;
        lat  = cyc - t0;
        data = bus.rsp_data;
        id   = bus.rsp_id;
        ok   = 1'b1;
        if (bus.rsp_ready) begin
            @(posedge clock);
            #1;
        end
    endtask

    typedef struct {
        int           port;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        int           id;
    } exp_t;

    initial begin
        vec_t            vecs [4];
        exp_t            expq [$];
        exp_t            e;
        logic [127:0]    d, hold_d;
        logic [ID_W-1:0] id, hold_id;
        int              lat, ce_cyc, ids [4], nrsp;
        bit              ok, both_ready;
        logic [127:0]    pend_pt [NUM_REQ];
        logic [127:0]    pend_key [NUM_REQ];
        logic [NUM_REQ-1:0] exp_ready;
        int              model_rr, t_acc, ce_cnt, acc_port, done_jobs, idx;
        bit              in_flight, prev_v, prev_stall;

        vecs[0] = '{0, K1, P1, C1};
        vecs[1] = '{0, K2, P2, C2};
        vecs[2] = '{0, K2, P2, C2};
        vecs[3] = '{1, K1, P1, C1};

        init_sbox();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_key   = '0;
        bus.rsp_ready = 1'b1;
        do_reset();
        @(negedge clock);
        check_reset_vals("reset values");

        // Vector table, single requester at a time (includes back-to-back on port 0).
        for (int v = 0; v < 4; v++) begin
            do_job(vecs[v].port, vecs[v].key, vecs[v].pt, d, id, lat, ce_cyc, ok);
            check($sformatf("vec%0d completed", v), ok, 1'b1);
            check($sformatf("vec%0d rsp_data", v), d, vecs[v].ct);
            check($sformatf("vec%0d rsp_id", v), id, vecs[v].port);
            check($sformatf("vec%0d latency", v), lat, ce_cyc + 3);
        end

        // Contention from reset: both ports valid continuously.
        do_reset();
        bus.req_data = {P2, P1};
        bus.req_key  = {K2, K1};
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        nrsp = 0; both_ready = 1'b0;
        for (int i = 0; i < 400 && nrsp < 4; i++) begin
            @(negedge clock);
            if (&bus.req_ready) both_ready = 1'b1;
            if (bus.rsp_valid) begin
                ids[nrsp] = int'(bus.rsp_id);
                check($sformatf("contention rsp%0d data", nrsp), bus.rsp_data, (nrsp % 2 == 0) ? C1 : C2);
                nrsp++;
            end
        end
        bus.req_valid = '0;
        check("contention responses", nrsp, 4);
        check("contention never both ready", both_ready, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("contention grant%0d", i), (i < nrsp) ? ids[i] : -1, i % 2);
        repeat (2) @(posedge clock);
        #1;

        // Backpressure: response held 20 cycles while port 1 waits.
        bus.rsp_ready = 1'b0;
        do_job(0, K2, P2, hold_d, hold_id, lat, ce_cyc, ok);
        check("bp completed", ok, 1'b1);
        bus.req_data[255:128] = P1;
        bus.req_key[255:128]  = K1;
        bus.req_valid[1]      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("bp held", {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, bus.core_ce},
                  {1'b1, C2, hold_id, {NUM_REQ{1'b0}}, 1'b0});
        end
        @(posedge clock);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clock);
        check("bp no grant in handshake cycle", bus.req_ready, '0);
        @(posedge clock);
        #1;
        do_job(1, K1, P1, d, id, lat, ce_cyc, ok);
        check("bp follow-up data", d, C1);
        check("bp follow-up id", id, 1);

        // Reset during RUN, 10 cycles into the job.
        core_slow = 1'b1;
        repeat (2) @(posedge clock);
        bus.req_data[127:0] = P2;
        bus.req_key[127:0]  = K2;
        #1 bus.req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (bus.req_ready[0]) ok = 1'b1;
        end
        check("midrun accepted", ok, 1'b1);
        @(posedge clock);
        #1 bus.req_valid[0] = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        check("midrun core_ce high before reset", bus.core_ce, 1'b1);
        reset = 1'b1;
        core_slow = 1'b0;
        @(negedge clock);
        check_reset_vals("midrun reset values");
        @(posedge clock);
        #1 reset = 1'b0;
        do_job(0, K1, P1, d, id, lat, ce_cyc, ok);
        check("post-reset job data", d, C1);
        check("post-reset job id", id, 0);

`ifdef AES_ARB_TIMEOUT_EN
        core_hang = 1'b1;
        do_job(1, K2, P2, d, id, lat, ce_cyc, ok);
        check("timeout completed", ok, 1'b1);
        check("timeout err", err, 1'b1);
        check("timeout rsp_data", d, '0);
        check("timeout core_ce", bus.core_ce, 1'b0);
        check("timeout ce cycles", ce_cyc, TIMEOUT_CYC);
        core_hang = 1'b0;
        do_job(0, K1, P1, d, id, lat, ce_cyc, ok);
        check("timeout err sticky", err, 1'b1);
        check("after timeout data", d, C1);
        do_reset();
        @(negedge clock);
        check_reset_vals("timeout reset values");
`endif

        // Randomized traffic against a round-robin / latency reference model.
        do_reset();
        bus.req_valid = '0;
        model_rr = NUM_REQ - 1; in_flight = 1'b0; acc_port = -1; done_jobs = 0;
        prev_v = 1'b0; prev_stall = 1'b0; t_acc = 0; ce_cnt = 0; hold_d = '0; hold_id = '0;
        for (int cy = 0; cy < 4000 && done_jobs < 40; cy++) begin
            @(posedge clock);
            #1;
            if (acc_port >= 0) begin
                bus.req_valid[acc_port] = 1'b0;
                acc_port = -1;
            end
            for (int p = 0; p < NUM_REQ; p++)
                if (!bus.req_valid[p] && $urandom_range(0, 3) == 0) begin
                    pend_pt[p]  = {$urandom, $urandom, $urandom, $urandom};
                    pend_key[p] = {$urandom, $urandom, $urandom, $urandom};
                    bus.req_data[128*p +: 128] = pend_pt[p];
                    bus.req_key[128*p +: 128]  = pend_key[p];
                    bus.req_valid[p] = 1'b1;
                end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            exp_ready = '0;
            if (!in_flight)
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (model_rr + k) % NUM_REQ;
                    if (exp_ready == '0 && bus.req_valid[idx]) exp_ready[idx] = 1'b1;
                end
            check("rand req_ready", bus.req_ready, exp_ready);
            check("rand core_ce only in job", bus.core_ce && !in_flight, 1'b0);
            if (in_flight && bus.core_ce) ce_cnt++;
            if (exp_ready != '0) begin
                for (int p = 0; p < NUM_REQ; p++)
                    if (exp_ready[p]) acc_port = p;
                e.data = aes_enc(pend_pt[acc_port], pend_key[acc_port]);
                e.id   = acc_port;
                expq.push_back(e);
                model_rr  = acc_port;
                in_flight = 1'b1;
                t_acc     = cyc + 1;
                ce_cnt    = 0;
            end
            if (bus.rsp_valid) begin
                if (!prev_v) check("rand latency", cyc - t_acc, ce_cnt + 3);
                if (prev_stall) check("rand rsp stable", {bus.rsp_data, bus.rsp_id}, {hold_d, hold_id});
                if (bus.rsp_ready) begin
                    if (expq.size() == 0) begin
                        check("rand unexpected response", 1'b1, 1'b0);
                    end else begin
                        e = expq.pop_front();
                        check("rand rsp_data", bus.rsp_data, e.data);
                        check("rand rsp_id", bus.rsp_id, e.id);
                    end
                    in_flight = 1'b0;
                    done_jobs++;
                end
            end
            prev_v     = bus.rsp_valid;
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            hold_d     = bus.rsp_data;
            hold_id    = bus.rsp_id;
        end
        check("rand jobs completed", done_jobs >= 40, 1'b1);
        bus.req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
